// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit: operand-select encodings,
// pipeline stage records and the forwarding priority rule.
package forwarding_hazard_unit_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  // Widest register address a stage record can hold; narrower addresses are zero-extended.
  localparam int REG_ADDR_W = 8;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } ex_stage_t;

  typedef struct packed {
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } mem_stage_t;

  typedef struct packed {
    reg_addr_t rd;
    logic      reg_write;
  } wb_stage_t;

  // A MEM-stage load has no result yet, so only ALU results forward from MEM; MEM beats WB.
  function automatic logic [1:0] fwd_select(mem_stage_t mem, wb_stage_t wb, reg_addr_t src);
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (mem.reg_write && !mem.mem_read && (mem.rd != '0) && (mem.rd == src)) begin
      sel = FWD_EXMEM;
    end else if (wb.reg_write && (wb.rd != '0) && (wb.rd == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage record register; a bubble loads all zeros
// (no write, no load, register 0 everywhere).
module hazard_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bubble_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = data_i;
    if (bubble_i) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Tracks EX/MEM/WB destination info to drive the EX operand-forwarding selects,
// detects load-use hazards and counts the stall cycles taken.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int NRegBits  = 5,
  parameter int CountBits = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRegBits-1:0]  ID_Rs1_i,
  input  logic [NRegBits-1:0]  ID_Rs2_i,
  input  logic [NRegBits-1:0]  ID_Rd_i,
  input  logic                 ID_RegWrite_i,
  input  logic                 ID_MemRead_i,
  input  logic                 ID_Valid_i,
  input  logic                 Flush_i,
  output logic [1:0]           Forward_A_o,
  output logic [1:0]           Forward_B_o,
  output logic                 Stall_o,
  output logic [CountBits-1:0] Stall_Count_o
);

  if (NRegBits > REG_ADDR_W) begin : g_width_check
    $error("NRegBits exceeds the stage record address width");
  end

  ex_stage_t  ex_d, ex_q;
  mem_stage_t mem_d, mem_q;
  wb_stage_t  wb_d, wb_q;
  reg_addr_t  id_rs1, id_rs2, id_rd;
  logic       stall;
  logic       ex_capture;
  logic [CountBits-1:0] stall_count_d, stall_count_q;

  assign id_rs1 = reg_addr_t'(ID_Rs1_i);
  assign id_rs2 = reg_addr_t'(ID_Rs2_i);
  assign id_rd  = reg_addr_t'(ID_Rd_i);

  // Load in EX whose result the ID instruction needs next cycle.
  assign stall = ID_Valid_i && ex_q.mem_read && (ex_q.rd != '0) &&
                 ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

  // Flush overrides stall: both just turn the EX load into a bubble.
  assign ex_capture = ID_Valid_i && !stall && !Flush_i;

  always_comb begin
    ex_d  = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd,
              reg_write: ID_RegWrite_i, mem_read: ID_MemRead_i};
    mem_d = '{rd: ex_q.rd, reg_write: ex_q.reg_write, mem_read: ex_q.mem_read};
    wb_d  = '{rd: mem_q.rd, reg_write: mem_q.reg_write};
  end

  hazard_stage_reg #(.W($bits(ex_stage_t))) u_ex_stage (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (!ex_capture),
    .data_i   (ex_d),
    .data_o   (ex_q)
  );

  hazard_stage_reg #(.W($bits(mem_stage_t))) u_mem_stage (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .data_i   (mem_d),
    .data_o   (mem_q)
  );

  hazard_stage_reg #(.W($bits(wb_stage_t))) u_wb_stage (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .data_i   (wb_d),
    .data_o   (wb_q)
  );

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !Flush_i && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign Forward_A_o   = fwd_select(mem_q, wb_q, ex_q.rs1);
  assign Forward_B_o   = fwd_select(mem_q, wb_q, ex_q.rs2);
  assign Stall_o       = stall;
  assign Stall_Count_o = stall_count_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: directed hazard scenarios followed by random
// instruction streams, all checked against a slot-history reference model.
module tb_forwarding_hazard_unit;

  localparam int NREG    = 5;
  localparam int CNTW    = 4;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic            clk;
  logic            reset;
  logic [NREG-1:0] ID_Rs1_i, ID_Rs2_i, ID_Rd_i;
  logic            ID_RegWrite_i, ID_MemRead_i, ID_Valid_i, Flush_i;
  logic [1:0]      Forward_A_o, Forward_B_o;
  logic            Stall_o;
  logic [CNTW-1:0] Stall_Count_o;

  int checks = 0;
  int errors = 0;

  forwarding_hazard_unit #(.NRegBits(NREG), .CountBits(CNTW)) dut (
    .clk           (clk),
    .reset         (reset),
    .ID_Rs1_i      (ID_Rs1_i),
    .ID_Rs2_i      (ID_Rs2_i),
    .ID_Rd_i       (ID_Rd_i),
    .ID_RegWrite_i (ID_RegWrite_i),
    .ID_MemRead_i  (ID_MemRead_i),
    .ID_Valid_i    (ID_Valid_i),
    .Flush_i       (Flush_i),
    .Forward_A_o   (Forward_A_o),
    .Forward_B_o   (Forward_B_o),
    .Stall_o       (Stall_o),
    .Stall_Count_o (Stall_Count_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: history of the last three issue slots, [0]=EX [1]=MEM [2]=WB
  typedef struct {
    int rd;
    int rs1;
    int rs2;
    bit rw;
    bit mr;
  } slot_t;

  slot_t pipe_q[$];
  int    m_count;

  function automatic slot_t bubble_slot();
    slot_t s;
    s.rd = 0; s.rs1 = 0; s.rs2 = 0; s.rw = 1'b0; s.mr = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    pipe_q.delete();
    repeat (3) pipe_q.push_back(bubble_slot());
    m_count = 0;
  endtask

  function automatic int exp_fwd(int src);
    slot_t mem, wb;
    mem = pipe_q[1];
    wb  = pipe_q[2];
    if (src == 0) return 0;
    if (mem.rw && !mem.mr && mem.rd == src) return 1;
    if (wb.rw && wb.rd == src) return 2;
    return 0;
  endfunction

  function automatic int exp_stall();
    slot_t ex;
    ex = pipe_q[0];
    if (ID_Valid_i && ex.mr && ex.rd != 0 &&
        (ex.rd == int'(ID_Rs1_i) || ex.rd == int'(ID_Rs2_i))) return 1;
    return 0;
  endfunction

  task automatic model_advance(int st);
    slot_t s;
    s = bubble_slot();
    if (ID_Valid_i && st == 0 && !Flush_i) begin
      s.rd = int'(ID_Rd_i); s.rs1 = int'(ID_Rs1_i); s.rs2 = int'(ID_Rs2_i);
      s.rw = ID_RegWrite_i; s.mr = ID_MemRead_i;
    end
    pipe_q.push_front(s);
    void'(pipe_q.pop_back());
    if (st != 0 && !Flush_i && m_count < CNT_MAX) m_count++;
  endtask

  // scoreboard compare
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".fwd_a"}, 32'(Forward_A_o), 32'(exp_fwd(pipe_q[0].rs1)));
    chk({tag, ".fwd_b"}, 32'(Forward_B_o), 32'(exp_fwd(pipe_q[0].rs2)));
    chk({tag, ".stall"}, 32'(Stall_o), 32'(exp_stall()));
    chk({tag, ".count"}, 32'(Stall_Count_o), 32'(m_count));
  endtask

  // driver: present one ID instruction, check the cycle, clock it in.
  // Directed expectations of -1 are not checked.
  task automatic step(string tag, int rs1, int rs2, int rd, bit rw, bit mr, bit valid, bit flush,
                      int e_fa, int e_fb, int e_st, int e_cnt);
    int st;
    ID_Rs1_i = NREG'(rs1); ID_Rs2_i = NREG'(rs2); ID_Rd_i = NREG'(rd);
    ID_RegWrite_i = rw; ID_MemRead_i = mr; ID_Valid_i = valid; Flush_i = flush;
    @(negedge clk);
    check_model(tag);
    if (e_fa >= 0)  chk({tag, ".dir_fwd_a"}, 32'(Forward_A_o), 32'(e_fa));
    if (e_fb >= 0)  chk({tag, ".dir_fwd_b"}, 32'(Forward_B_o), 32'(e_fb));
    if (e_st >= 0)  chk({tag, ".dir_stall"}, 32'(Stall_o), 32'(e_st));
    if (e_cnt >= 0) chk({tag, ".dir_count"}, 32'(Stall_Count_o), 32'(e_cnt));
    st = exp_stall();
    @(posedge clk);
    model_advance(st);
    #1;
  endtask

  task automatic nop(string tag, int e_fa, int e_fb, int e_st, int e_cnt);
    step(tag, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, e_fa, e_fb, e_st, e_cnt);
  endtask

  initial begin
    reset = 1'b1;
    ID_Rs1_i = '0; ID_Rs2_i = '0; ID_Rd_i = '0;
    ID_RegWrite_i = 1'b0; ID_MemRead_i = 1'b0; ID_Valid_i = 1'b0; Flush_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.fwd_a", 32'(Forward_A_o), 32'd0);
    chk("reset.fwd_b", 32'(Forward_B_o), 32'd0);
    chk("reset.stall", 32'(Stall_o), 32'd0);
    chk("reset.count", 32'(Stall_Count_o), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    model_advance(0);

    // EX/MEM forward to rs1
    step("fwd_exmem.add", 1, 2, 5, 1, 0, 1, 0, -1, -1, 0, -1);
    step("fwd_exmem.sub", 5, 6, 8, 1, 0, 1, 0, -1, -1, 0, -1);
    nop("fwd_exmem.ex", 1, 0, 0, 0);

    // MEM/WB forward to rs2
    step("fwd_memwb.add", 1, 2, 5, 1, 0, 1, 0, -1, -1, -1, -1);
    step("fwd_memwb.ind", 1, 2, 9, 1, 0, 1, 0, -1, -1, -1, -1);
    step("fwd_memwb.use", 4, 5, 10, 1, 0, 1, 0, -1, -1, -1, -1);
    nop("fwd_memwb.ex", 0, 2, 0, 0);

    // load-use stall
    step("ldu.lw", 1, 2, 7, 1, 1, 1, 0, -1, -1, 0, 0);
    step("ldu.use", 7, 1, 11, 1, 0, 1, 0, -1, -1, 1, 0);
    step("ldu.retry", 7, 1, 11, 1, 0, 1, 0, -1, -1, 0, 1);
    nop("ldu.ex", 2, 0, 0, 1);

    // MEM beats WB
    step("prio.w1", 1, 2, 3, 1, 0, 1, 0, -1, -1, -1, -1);
    step("prio.w2", 1, 2, 3, 1, 0, 1, 0, -1, -1, -1, -1);
    step("prio.rd", 3, 3, 12, 1, 0, 1, 0, -1, -1, -1, -1);
    nop("prio.ex", 1, 1, 0, 1);

    // register 0 never forwards or stalls
    step("x0.w", 1, 2, 0, 1, 1, 1, 0, -1, -1, -1, -1);
    step("x0.rd", 0, 0, 13, 1, 0, 1, 0, 0, 0, 0, -1);
    nop("x0.ex", 0, 0, 0, 1);

    // flush wins over stall
    step("flush.lw", 1, 2, 7, 1, 1, 1, 0, -1, -1, -1, 1);
    step("flush.use", 7, 1, 11, 1, 0, 1, 1, -1, -1, 1, 1);
    nop("flush.after", 0, 0, 0, 1);

    // async reset while a load sits in EX with a forward active
    step("rst.add", 1, 2, 4, 1, 0, 1, 0, -1, -1, -1, -1);
    step("rst.lw", 4, 2, 7, 1, 1, 1, 0, -1, -1, -1, -1);
    ID_Rs1_i = NREG'(7); ID_Rs2_i = NREG'(0); ID_Rd_i = NREG'(11);
    ID_RegWrite_i = 1'b1; ID_MemRead_i = 1'b0; ID_Valid_i = 1'b1; Flush_i = 1'b0;
    #1;
    chk("rst.pre_stall", 32'(Stall_o), 32'd1);
    chk("rst.pre_fwd_a", 32'(Forward_A_o), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst.stall", 32'(Stall_o), 32'd0);
    chk("rst.fwd_a", 32'(Forward_A_o), 32'd0);
    chk("rst.fwd_b", 32'(Forward_B_o), 32'd0);
    chk("rst.count", 32'(Stall_Count_o), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    model_advance(0);
    step("post_rst.add", 1, 2, 5, 1, 0, 1, 0, -1, -1, -1, 0);
    step("post_rst.sub", 5, 6, 8, 1, 0, 1, 0, -1, -1, -1, -1);
    nop("post_rst.ex", 1, 0, 0, 0);

    // counter saturation
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      step("sat.lw", 1, 2, 7, 1, 1, 1, 0, -1, -1, -1, -1);
      step("sat.use", 7, 7, 9, 1, 0, 1, 0, -1, -1, 1, -1);
      step("sat.retry", 7, 7, 9, 1, 0, 1, 0, -1, -1, 0, -1);
    end
    nop("sat.hold", -1, -1, 0, CNT_MAX);

    // random instruction stream
    for (int i = 0; i < 400; i++) begin
      int r_mr;
      r_mr = ($urandom_range(0, 3) == 0) ? 1 : 0;
      step("rand",
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           (r_mr != 0) || ($urandom_range(0, 3) != 0), r_mr != 0,
           $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
           -1, -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
